// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the mips_cpu_harvard bench-side memories.
package mips_tb_pkg;

  typedef enum logic [1:0] {LD_IDLE, LD_LOADING, LD_READY} loader_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h0;
  localparam logic [31:0] NOP_WORD     = 32'h0;

endpackage

// File: rtl/instr_rom_loader_rom_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read.
module rom_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_rom_loader.sv
// Instruction ROM for the Harvard fetch port, loaded by a valid/ready beat stream.
module instr_rom_loader
  import mips_tb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enable,
  input  logic [31:0]     instr_address,
  output logic [31:0]     instr_readdata,
  input  logic            load_valid,
  input  logic [31:0]     load_data,
  input  logic            load_last,
  output logic            load_ready,
  input  logic            load_clear,
  output logic            load_done,
  output logic [ADDR_W:0] load_count,
  output logic            fetch_fault
);

  localparam logic [31:0]       SPAN     = 32'(4 * DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_q;
  logic              fault_q;
  logic              beat, wr_en, last_beat;
  logic [31:0]       off, rd_word;
  logic [ADDR_W-1:0] idx;
  logic              aligned, in_range, hit, bad_fetch;

  assign load_ready = reset && clk_enable &&
                      (state_q == LD_IDLE || state_q == LD_LOADING);
  assign beat      = load_valid && load_ready;
  assign wr_en     = beat && !load_clear;
  // Filling the last slot ends the image even without load_last.
  assign last_beat = load_last || (wr_ptr == LAST_IDX);

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          state_q <= LD_IDLE;
    else if (clk_enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load_clear) begin
      state_d = LD_IDLE;
    end else begin
      case (state_q)
        LD_IDLE:    if (beat) state_d = last_beat ? LD_READY : LD_LOADING;
        LD_LOADING: if (beat && last_beat) state_d = LD_READY;
        LD_READY:   state_d = LD_READY;
        default:    state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else if (clk_enable) begin
      if (load_clear) begin
        wr_ptr  <= '0;
        count_q <= '0;
        fault_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
        end
        if (bad_fetch) fault_q <= 1'b1;
      end
    end
  end

  rom_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rom (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (idx),
    .rdata (rd_word)
  );

  // Fetch decode; anything not a loaded, aligned, in-range word reads as NOP
  assign off       = instr_address - BASE_ADDR;
  assign idx       = off[ADDR_W+1:2];
  assign aligned   = (off[1:0] == 2'b00);
  assign in_range  = (off < SPAN);
  assign hit       = (state_q == LD_READY) && aligned && in_range &&
                     ({1'b0, idx} < count_q);
  assign bad_fetch = (state_q == LD_READY) && (instr_address != HALT_ADDR) &&
                     (!aligned || !in_range);

  assign instr_readdata = hit ? rd_word : NOP_WORD;
  assign load_done      = (state_q == LD_READY);
  assign load_count     = count_q;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Self-checking bench for instr_rom_loader (DEPTH=256 and DEPTH=4 instances).
module tb_instr_rom_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk, reset, clk_enable, load_clear;
  logic [31:0] instr_address, load_data, instr_readdata;
  logic        load_valid, load_last, load_ready, load_done, fetch_fault;
  logic [8:0]  load_count;

  logic [31:0] a4, d4, rd4;
  logic        v4, l4, rdy4, done4, fault4;
  logic [2:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  instr_rom_loader dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_clear(load_clear), .load_done(load_done),
    .load_count(load_count), .fetch_fault(fetch_fault)
  );

  instr_rom_loader #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .instr_address(a4), .instr_readdata(rd4),
    .load_valid(v4), .load_data(d4), .load_last(l4),
    .load_ready(rdy4), .load_clear(load_clear), .load_done(done4),
    .load_count(cnt4), .fetch_fault(fault4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model of the DEPTH=256 instance: the image is a list of words.
  logic [31:0] img[$];
  bit          m_ready, m_fault;

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    logic [31:0] o;
    o = addr - BASE;
    if (!m_ready || o[1:0] != 2'b00 || o >= 32'd1024) return 32'h0;
    if ((o >> 2) < img.size()) return img[o >> 2];
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] o;
    o = instr_address - BASE;
    if (!reset) begin
      img.delete(); m_ready = 0; m_fault = 0;
    end else if (clk_enable) begin
      if (load_clear) begin
        img.delete(); m_ready = 0; m_fault = 0;
      end else begin
        if (m_ready && instr_address != 32'h0 && (o[1:0] != 2'b00 || o >= 32'd1024))
          m_fault = 1;
        if (!m_ready && load_valid) begin
          img.push_back(load_data);
          if (load_last || img.size() == 256) m_ready = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        fault;
  } fetch_vec_t;

  fetch_vec_t  tbl[9];
  logic [31:0] prog[4];

  initial begin
    tbl[0] = '{32'hBFC00000, 32'h24840003, 1'b0};
    tbl[1] = '{32'hBFC00004, 32'h38820006, 1'b0};
    tbl[2] = '{32'hBFC00008, 32'h00000008, 1'b0};
    tbl[3] = '{32'hBFC0000C, 32'h24000000, 1'b0};
    tbl[4] = '{32'hBFC00010, 32'h00000000, 1'b0};
    tbl[5] = '{32'hBFC003FC, 32'h00000000, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b0};
    tbl[7] = '{32'hBFC00002, 32'h00000000, 1'b1};
    tbl[8] = '{32'hBFC00400, 32'h00000000, 1'b1};
    prog[0] = 32'h24840003; prog[1] = 32'h38820006;
    prog[2] = 32'h00000008; prog[3] = 32'h24000000;

    reset = 0; clk_enable = 1; load_clear = 0;
    instr_address = BASE; load_valid = 0; load_data = 0; load_last = 0;
    a4 = BASE; v4 = 0; d4 = 0; l4 = 0;
    #1;
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_count", 32'(load_count), 32'h0);
    chk("rst_done",  32'(load_done),  32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    tick(); tick();
    reset = 1;
    #1;
    chk("idle_fetch", instr_readdata, 32'h0);
    chk("idle_ready", 32'(load_ready), 32'h1);

    // Four-word image
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = prog[i]; load_last = (i == 3);
      #1;
      chk("beat_ready", 32'(load_ready), 32'h1);
      tick();
      if (i == 0) chk("loading_fetch", instr_readdata, 32'h0);
    end
    load_valid = 0; load_last = 0;
    #1;
    chk("img_count", 32'(load_count), 32'd4);
    chk("img_done",  32'(load_done),  32'h1);

    foreach (tbl[i]) begin
      instr_address = tbl[i].addr;
      #1;
      chk("tbl_rd", instr_readdata, tbl[i].rd);
      tick();
      chk("tbl_fault", 32'(fetch_fault), 32'(tbl[i].fault));
    end
    instr_address = BASE;

    // Beats offered in READY are ignored
    load_valid = 1; load_data = 32'h12345678;
    #1;
    chk("ready_blocks", 32'(load_ready), 32'h0);
    tick();
    load_valid = 0;
    chk("ready_count", 32'(load_count), 32'd4);
    chk("ready_word0", instr_readdata, 32'h24840003);

    // Clear overrides a simultaneous beat
    load_clear = 1; tick();
    load_valid = 1; load_data = 32'hCAFEF00D; tick();
    load_clear = 0; load_valid = 0;
    #1;
    chk("clr_count", 32'(load_count), 32'h0);
    chk("clr_done",  32'(load_done),  32'h0);
    chk("clr_fault", 32'(fetch_fault), 32'h0);

    // clk_enable low blocks beats
    clk_enable = 0; load_valid = 1; load_data = 32'h11111111;
    #1;
    chk("ce_ready", 32'(load_ready), 32'h0);
    tick();
    clk_enable = 1; load_valid = 0;
    chk("ce_count", 32'(load_count), 32'h0);

    // Reset in the middle of a load
    load_valid = 1; load_data = 32'hAAAA0001; tick();
    load_data = 32'hAAAA0002; tick();
    load_valid = 0;
    chk("mid_count", 32'(load_count), 32'd2);
    reset = 0;
    #1;
    chk("mid_rst_count", 32'(load_count), 32'h0);
    chk("mid_rst_ready", 32'(load_ready), 32'h0);
    tick();
    reset = 1;
    load_valid = 1; load_data = 32'hDEADBEEF; load_last = 1; tick();
    load_valid = 0; load_last = 0;
    instr_address = BASE;
    #1;
    chk("reload_w0", instr_readdata, 32'hDEADBEEF);
    instr_address = BASE + 32'd4;
    #1;
    chk("reload_w1", instr_readdata, 32'h0);

    // clk_enable low holds state against clear; reads stay live
    clk_enable = 0; load_clear = 1; instr_address = BASE; tick();
    load_clear = 0; clk_enable = 1;
    #1;
    chk("ce_hold_done", 32'(load_done), 32'h1);
    chk("ce_hold_rd", instr_readdata, 32'hDEADBEEF);

    // DEPTH=4: fill implies last; extra beats refused
    load_clear = 1; tick(); load_clear = 0;
    for (int i = 0; i < 6; i++) begin
      v4 = 1; d4 = 32'h100 + i;
      #1;
      chk("d4_ready", 32'(rdy4), (i < 4) ? 32'h1 : 32'h0);
      tick();
    end
    v4 = 0;
    chk("d4_count", 32'(cnt4), 32'd4);
    chk("d4_done",  32'(done4), 32'h1);
    a4 = BASE + 32'hC;
    #1;
    chk("d4_last_word", rd4, 32'h103);
    a4 = BASE + 32'h10;
    #1;
    chk("d4_oob_rd", rd4, 32'h0);
    tick();
    chk("d4_oob_fault", 32'(fault4), 32'h1);

    // Randomized traffic against the model
    load_clear = 1; tick(); load_clear = 0;
    for (int c = 0; c < 2000; c++) begin
      clk_enable = ($urandom % 8) != 0;
      load_valid = $urandom % 2;
      load_data  = $urandom;
      load_last  = ($urandom % 40) == 0;
      load_clear = ($urandom % 150) == 0;
      case ($urandom % 8)
        0:       instr_address = 32'h0;
        1:       instr_address = $urandom;
        default: instr_address = BASE + $urandom_range(0, 1100);
      endcase
      #1;
      chk("rnd_rd",    instr_readdata, exp_rd(instr_address));
      chk("rnd_ready", 32'(load_ready), 32'(!m_ready && clk_enable));
      chk("rnd_count", 32'(load_count), 32'(img.size()));
      chk("rnd_done",  32'(load_done), 32'(m_ready));
      chk("rnd_fault", 32'(fetch_fault), 32'(m_fault));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
